// File: rtl/cva5_types.sv
// Shared types for the multiplier-sharing slice: result tag and the request bundle
// a requester presents to the shared multiplier.
package cva5_types;

    localparam int ID_W = 4;

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic [32:0] rs1;
        logic [32:0] rs2;
        logic        mulh;
        id_t         id;
    } mul_share_req_t;

endpackage

// File: rtl/mul_pipe_core.sv
// Two-stage shared multiplier: stage 0 captures the request, stage 1 holds the product.
// Each stage loads only when its advance input is high.
module mul_pipe_core
    import cva5_types::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           adv0,
    input  logic           adv1,
    input  logic           in_valid,
    input  mul_share_req_t in_req,
    input  logic           in_owner,
    output logic           v0,
    output logic           v1,
    output logic           owner1,
    output logic           mulh1,
    output id_t            id1,
    output logic [63:0]    product
);

    mul_share_req_t req0;
    logic           owner0;
    logic [63:0]    rs1_ext;
    logic [63:0]    rs2_ext;

    // Sign-extending to 64 bits keeps exactly the low 64 bits of the 66-bit product.
    always_comb begin
        rs1_ext = {{31{req0.rs1[32]}}, req0.rs1};
        rs2_ext = {{31{req0.rs2[32]}}, req0.rs2};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else begin
            if (adv0) v0 <= in_valid;
            if (adv1) v1 <= v0;
        end
    end

    always_ff @(posedge clk) begin
        if (adv0) begin
            req0   <= in_req;
            owner0 <= in_owner;
        end
        if (adv1) begin
            product <= rs1_ext * rs2_ext;
            owner1  <= owner0;
            mulh1   <= req0.mulh;
            id1     <= req0.id;
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between two requesters;
// results return to the owning port in grant order.
module mul_share_arbiter
    import cva5_types::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int INIT_PRIORITY = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0][32:0]     req_rs1,
    input  logic [NUM_REQ-1:0][32:0]     req_rs2,
    input  logic [NUM_REQ-1:0]           req_mulh,
    input  id_t  [NUM_REQ-1:0]           req_id,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ack,
    output logic [31:0]                  resp_rd,
    output id_t                          resp_id
);

    logic           v0;
    logic           v1;
    logic           owner1;
    logic           mulh1;
    id_t            id1;
    logic [63:0]    product;
    logic           adv0;
    logic           adv1;
    logic           last_grant;
    logic           grant_idx;
    logic           xfer;
    mul_share_req_t sel;

    always_comb begin
        grant_idx = 1'b0;
        if (req_valid[0] && req_valid[1]) grant_idx = ~last_grant;
        else if (req_valid[1])            grant_idx = 1'b1;

        adv1 = ~v1 | resp_ack[owner1];
        adv0 = ~v0 | adv1;

        req_ready = '0;
        if (!rst && adv0 && (|req_valid)) req_ready[grant_idx] = 1'b1;
        xfer = |req_ready;

        sel.rs1  = req_rs1[grant_idx];
        sel.rs2  = req_rs2[grant_idx];
        sel.mulh = req_mulh[grant_idx];
        sel.id   = req_id[grant_idx];
    end

    always_ff @(posedge clk) begin
        if (rst)       last_grant <= (INIT_PRIORITY == 0);
        else if (xfer) last_grant <= grant_idx;
    end

    mul_pipe_core u_core (
        .clk      (clk),
        .rst      (rst),
        .adv0     (adv0),
        .adv1     (adv1),
        .in_valid (xfer),
        .in_req   (sel),
        .in_owner (grant_idx),
        .v0       (v0),
        .v1       (v1),
        .owner1   (owner1),
        .mulh1    (mulh1),
        .id1      (id1),
        .product  (product)
    );

    // Results are suppressed while rst is high so a stale stage 1 never shows.
    always_comb begin
        resp_valid = '0;
        if (v1 && !rst) resp_valid[owner1] = 1'b1;
        resp_rd = mulh1 ? product[63:32] : product[31:0];
        resp_id = id1;
    end

endmodule
